// File: rtl/conv_mc_ctrl_fsm.sv
// Multi-channel convolution tile controller: sequences source/sink/engine start,
// counts output beats per channel, waits for transfer completion, iterates tiles.
module conv_mc_ctrl_fsm #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int CNT_W  = 11,
  parameter int ITER_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   trigger_i,
  input  logic [ITER_W-1:0]      nb_iter_i,
  input  logic [N_OUT*CNT_W-1:0] cnt_limit_i,
  input  logic [N_OUT-1:0]       out_hs_i,
  input  logic [N_IN-1:0]        source_done_i,
  input  logic [N_OUT-1:0]       sink_done_i,
  output logic [N_IN-1:0]        source_start_o,
  output logic [N_OUT-1:0]       sink_start_o,
  output logic                   engine_start_o,
  output logic                   engine_clear_o,
  output logic [ITER_W-1:0]      iter_idx_o,
  output logic [N_OUT*CNT_W-1:0] cnt_o,
  output logic [2:0]             state_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_COMPUTE   = 3'd2,
    S_WAIT      = 3'd3,
    S_UPDATEIDX = 3'd4,
    S_TERMINATE = 3'd5
  } state_t;

  state_t                 state;
  logic [ITER_W-1:0]      nb_iter_q;
  logic [N_OUT*CNT_W-1:0] lim_q;
  logic [N_OUT*CNT_W-1:0] cnt_nxt;
  logic [N_IN-1:0]        src_flag;
  logic [N_IN-1:0]        src_flag_nxt;
  logic [N_OUT-1:0]       snk_flag;
  logic [N_OUT-1:0]       snk_flag_nxt;
  logic [N_OUT-1:0]       cnt_full;
  logic                   all_full;
  logic                   all_flags;
  logic                   hs_err;
  logic                   last_iter;

  // A handshake on a channel already at its limit is an overrun: count holds, error flagged.
  always_comb begin
    cnt_nxt  = cnt_o;
    cnt_full = '0;
    hs_err   = 1'b0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      cnt_full[k] = (cnt_o[k*CNT_W +: CNT_W] == lim_q[k*CNT_W +: CNT_W]);
      if (out_hs_i[k]) begin
        if (cnt_full[k]) hs_err = 1'b1;
        else cnt_nxt[k*CNT_W +: CNT_W] = cnt_o[k*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign src_flag_nxt = src_flag | source_done_i;
  assign snk_flag_nxt = snk_flag | sink_done_i;
  assign all_full     = &cnt_full;
  assign all_flags    = (&src_flag_nxt) & (&snk_flag_nxt);
  assign last_iter    = ((iter_idx_o + ITER_W'(1)) == nb_iter_q);
  assign state_o      = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      nb_iter_q      <= '0;
      lim_q          <= '0;
      src_flag       <= '0;
      snk_flag       <= '0;
      source_start_o <= '0;
      sink_start_o   <= '0;
      engine_start_o <= 1'b0;
      engine_clear_o <= 1'b0;
      iter_idx_o     <= '0;
      cnt_o          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      source_start_o <= '0;
      sink_start_o   <= '0;
      engine_start_o <= 1'b0;
      engine_clear_o <= 1'b0;
      done_o         <= 1'b0;
      if (clear_i) begin
        state          <= S_IDLE;
        cnt_o          <= '0;
        src_flag       <= '0;
        snk_flag       <= '0;
        iter_idx_o     <= '0;
        err_o          <= 1'b0;
        busy_o         <= 1'b0;
        engine_clear_o <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (trigger_i) begin
              nb_iter_q  <= nb_iter_i;
              lim_q      <= cnt_limit_i;
              err_o      <= 1'b0;
              iter_idx_o <= '0;
              if (nb_iter_i != '0) begin
                // Start pulses are launched on entry so they coincide with the START cycle.
                state          <= S_START;
                busy_o         <= 1'b1;
                source_start_o <= '1;
                sink_start_o   <= '1;
                engine_start_o <= 1'b1;
                cnt_o          <= '0;
                src_flag       <= '0;
                snk_flag       <= '0;
              end else begin
                done_o <= 1'b1;
              end
            end
          end
          S_START: state <= S_COMPUTE;
          S_COMPUTE, S_WAIT: begin
            cnt_o    <= cnt_nxt;
            src_flag <= src_flag_nxt;
            snk_flag <= snk_flag_nxt;
            if (hs_err) err_o <= 1'b1;
            if (state == S_COMPUTE && all_full) state <= S_WAIT;
            if (state == S_WAIT && all_flags) state <= S_UPDATEIDX;
          end
          S_UPDATEIDX: begin
            if (last_iter) begin
              state  <= S_TERMINATE;
              done_o <= 1'b1;
            end else begin
              iter_idx_o     <= iter_idx_o + ITER_W'(1);
              state          <= S_START;
              source_start_o <= '1;
              sink_start_o   <= '1;
              engine_start_o <= 1'b1;
              cnt_o          <= '0;
              src_flag       <= '0;
              snk_flag       <= '0;
            end
          end
          S_TERMINATE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_mc_ctrl_fsm.sv
// Directed bench for conv_mc_ctrl_fsm: job-level reference model checked every cycle,
// plus literal expectations per scenario.
module tb_conv_mc_ctrl_fsm;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int CW = 11;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic trigger = 1'b0;
  logic [IW-1:0] nb_iter = '0;
  logic [NO*CW-1:0] cnt_limit = '0;
  logic [NO-1:0] out_hs = '0;
  logic [NI-1:0] source_done = '0;
  logic [NO-1:0] sink_done = '0;
  logic [NI-1:0] source_start;
  logic [NO-1:0] sink_start;
  logic engine_start, engine_clear, busy, done, err;
  logic [IW-1:0] iter_idx;
  logic [NO*CW-1:0] cnt;
  logic [2:0] state;

  conv_mc_ctrl_fsm #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW), .ITER_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .trigger_i(trigger),
    .nb_iter_i(nb_iter), .cnt_limit_i(cnt_limit), .out_hs_i(out_hs),
    .source_done_i(source_done), .sink_done_i(sink_done),
    .source_start_o(source_start), .sink_start_o(sink_start),
    .engine_start_o(engine_start), .engine_clear_o(engine_clear),
    .iter_idx_o(iter_idx), .cnt_o(cnt), .state_o(state), .busy_o(busy),
    .done_o(done), .err_o(err));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase numbers are the externally visible state codes.
  int m_phase, m_iter, m_nb;
  int m_cnt[NO];
  int m_lim[NO];
  bit m_src[NI];
  bit m_snk[NO];
  bit m_start, m_eclr, m_done, m_err;

  task automatic mdl_new_tile();
    m_phase = 1;
    m_start = 1;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    foreach (m_src[j]) m_src[j] = 0;
    foreach (m_snk[k]) m_snk[k] = 0;
  endtask

  task automatic mdl_reset();
    m_phase = 0; m_iter = 0; m_nb = 0;
    foreach (m_cnt[k]) begin m_cnt[k] = 0; m_lim[k] = 0; m_snk[k] = 0; end
    foreach (m_src[j]) m_src[j] = 0;
    m_start = 0; m_eclr = 0; m_done = 0; m_err = 0;
  endtask

  task automatic mdl_step();
    int reached, nflags;
    m_start = 0; m_eclr = 0; m_done = 0;
    if (clear) begin
      m_phase = 0; m_iter = 0; m_err = 0; m_eclr = 1;
      foreach (m_cnt[k]) begin m_cnt[k] = 0; m_snk[k] = 0; end
      foreach (m_src[j]) m_src[j] = 0;
    end else if (m_phase == 0) begin
      if (trigger) begin
        m_nb = int'(nb_iter); m_err = 0; m_iter = 0;
        foreach (m_lim[k]) m_lim[k] = int'(cnt_limit[k*CW +: CW]);
        if (m_nb != 0) mdl_new_tile();
        else m_done = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 || m_phase == 3) begin
      reached = 0;
      foreach (m_cnt[k]) if (m_cnt[k] == m_lim[k]) reached++;
      foreach (m_cnt[k]) if (out_hs[k]) begin
        if (m_cnt[k] < m_lim[k]) m_cnt[k]++;
        else m_err = 1;
      end
      nflags = 0;
      foreach (m_src[j]) begin m_src[j] |= source_done[j]; nflags += int'(m_src[j]); end
      foreach (m_snk[k]) begin m_snk[k] |= sink_done[k]; nflags += int'(m_snk[k]); end
      if (m_phase == 2) begin
        if (reached == NO) m_phase = 3;
      end else if (nflags == NI + NO) m_phase = 4;
    end else if (m_phase == 4) begin
      if (m_iter + 1 == m_nb) begin m_phase = 5; m_done = 1; end
      else begin m_iter++; mdl_new_tile(); end
    end else begin
      m_phase = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) mdl_reset();
    else mdl_step();
  end

  // Per-cycle compare plus event monitors
  int n_start = 0, n_done = 0;
  bit busy_seen = 0;
  int start_iters[$];
  always @(negedge clk) begin
    logic [NO*CW-1:0] exp_cnt;
    for (int k = 0; k < NO; k++) exp_cnt[k*CW +: CW] = CW'(m_cnt[k]);
    chk("state", state, m_phase);
    chk("busy", busy, (m_phase != 0));
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("iter_idx", iter_idx, m_iter);
    chk("cnt", cnt, exp_cnt);
    chk("source_start", source_start, m_start ? 2'b11 : 2'b00);
    chk("sink_start", sink_start, m_start ? 2'b11 : 2'b00);
    chk("engine_start", engine_start, m_start);
    chk("engine_clear", engine_clear, m_eclr);
    if (engine_start) begin n_start++; start_iters.push_back(int'(iter_idx)); end
    if (done) n_done++;
    if (busy) busy_seen = 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_phase(int p);
    int n = 0;
    while (m_phase != p && n < 200) begin tick(); n++; end
    if (m_phase != p) chk("wait_timeout", m_phase, p);
  endtask

  task automatic start_job(int nb, int l0, int l1);
    nb_iter = IW'(nb);
    cnt_limit = {CW'(l1), CW'(l0)};
    trigger = 1;
    tick();
    trigger = 0;
  endtask

  task automatic run_tile(int h0, int h1, bit early_sink, bit extra_hs1);
    int mx;
    mx = (h0 > h1) ? h0 : h1;
    wait_phase(2);
    for (int i = 0; i < mx; i++) begin
      out_hs = {(i < h1), (i < h0)};
      if (early_sink && i == 0) sink_done = '1;
      tick();
      out_hs = '0;
      sink_done = '0;
    end
    wait_phase(3);
    if (extra_hs1) begin
      out_hs = 2'b10;
      tick();
      out_hs = '0;
      chk("overrun_err", err, 1);
      chk("overrun_cnt1", cnt[CW +: CW], 2);
    end
    source_done = '1;
    if (!early_sink) sink_done = '1;
    tick();
    source_done = '0;
    sink_done = '0;
  endtask

  initial begin
    int d0;
    repeat (2) tick();
    chk("reset_state", state, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_busy", busy, 0);
    rst = 0;
    tick();

    // Three tiles, limits {4,2}
    n_start = 0; n_done = 0; start_iters.delete();
    start_job(3, 4, 2);
    repeat (3) run_tile(4, 2, 0, 0);
    wait_phase(0);
    tick();
    chk("t1_starts", n_start, 3);
    chk("t1_dones", n_done, 1);
    chk("t1_err", err, 0);
    chk("t1_iter_last", iter_idx, 2);
    chk("t1_iter_seq_len", start_iters.size(), 3);
    for (int i = 0; i < start_iters.size(); i++) chk("t1_iter_seq", start_iters[i], i);

    // Zero-length job
    busy_seen = 0; d0 = n_done;
    start_job(0, 4, 2);
    chk("t2_done_next", done, 1);
    tick();
    chk("t2_done_once", n_done - d0, 1);
    chk("t2_busy_never", busy_seen, 0);

    // Sink done arrives early in COMPUTE; only source done in WAIT
    d0 = n_done;
    start_job(1, 4, 2);
    run_tile(4, 2, 1, 0);
    wait_phase(0);
    chk("t3_done", n_done - d0, 1);

    // Overrun on channel 1 in WAIT
    d0 = n_done;
    start_job(1, 1, 2);
    run_tile(1, 2, 0, 1);
    wait_phase(0);
    chk("t4_done", n_done - d0, 1);
    chk("t4_err_sticky", err, 1);

    // Channel with zero limit completes immediately; new trigger clears err
    d0 = n_done;
    start_job(1, 3, 0);
    chk("t5_err_cleared", err, 0);
    run_tile(3, 0, 0, 0);
    wait_phase(0);
    chk("t5_done", n_done - d0, 1);

    // Clear during COMPUTE at count 3; mid-job trigger ignored
    d0 = n_done;
    start_job(2, 4, 2);
    wait_phase(2);
    trigger = 1; nb_iter = '0;
    for (int i = 0; i < 3; i++) begin out_hs = 2'b01; tick(); trigger = 0; end
    out_hs = '0;
    chk("t6_cnt_before", cnt[CW-1:0], 3);
    clear = 1;
    tick();
    clear = 0;
    chk("t6_state", state, 0);
    chk("t6_cnt", cnt, 0);
    chk("t6_eclr", engine_clear, 1);
    chk("t6_no_done", done, 0);
    tick();
    chk("t6_done_total", n_done - d0, 0);

    // Async reset in WAIT
    d0 = n_done;
    start_job(1, 1, 1);
    wait_phase(2);
    out_hs = 2'b11;
    tick();
    out_hs = '0;
    wait_phase(3);
    #2 rst = 1;
    #1;
    chk("t7_state", state, 0);
    chk("t7_busy", busy, 0);
    chk("t7_cnt", cnt, 0);
    chk("t7_iter", iter_idx, 0);
    tick();
    rst = 0;
    repeat (3) tick();
    chk("t7_no_done", n_done - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/conv_mc_ctrl_fsm.md
CONV_MC_CTRL_FSM -- requirements
Module: conv_mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter N_IN, default 2: number of input source channels (1..8).
REQ-002 SHALL have parameter N_OUT, default 2: number of output sink channels (1..8).
REQ-003 SHALL have parameter CNT_W, default 11: per-output handshake counter width.
REQ-004 SHALL have parameter ITER_W, default 16: iteration counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports, in order:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- clear_i  in  1  sync soft clear
- trigger_i  in  1  job start pulse
- nb_iter_i  in  ITER_W  tiles per job
- cnt_limit_i  in  N_OUT*CNT_W  per-output beat limit, channel k at bits [k*CNT_W +: CNT_W]
- out_hs_i  in  N_OUT  output stream handshake (valid&ready) per channel
- source_done_i  in  N_IN  source transfer-done pulses
- sink_done_i  in  N_OUT  sink transfer-done pulses
- source_start_o  out  N_IN  source start pulses
- sink_start_o  out  N_OUT  sink start pulses
- engine_start_o  out  1  kernel start pulse
- engine_clear_o  out  1  kernel clear pulse
- iter_idx_o  out  ITER_W  current tile index
- cnt_o  out  N_OUT*CNT_W  per-output beat counts
- state_o  out  3  encoded state
- busy_o  out  1  job in progress
- done_o  out  1  job-complete pulse
- err_o  out  1  sticky overrun flag

Function
REQ-007 SHALL implement states IDLE=0, START=1, COMPUTE=2, WAIT=3, UPDATEIDX=4, TERMINATE=5, driven on state_o.
REQ-008 IDLE: on trigger_i, SHALL latch nb_iter_i and cnt_limit_i, clear err_o, zero iter_idx_o; go to START if nb_iter_i!=0, else pulse done_o next cycle and stay IDLE.
REQ-009 START: one cycle; SHALL assert all source_start_o, sink_start_o, engine_start_o; zero all counts and sticky done flags; go to COMPUTE.
REQ-010 COMPUTE: per channel k, out_hs_i[k] SHALL increment count k while count k < limit k; go to WAIT when every count equals its limit.
REQ-011 A channel with limit 0 SHALL be considered complete immediately.
REQ-012 out_hs_i[k] while count k == limit k, in COMPUTE or WAIT, SHALL set err_o without changing the count.
REQ-013 source_done_i/sink_done_i SHALL be captured into per-channel sticky flags in any cycle from COMPUTE through WAIT, so done pulses arriving before count completion are not lost.
REQ-014 WAIT: when all N_IN+N_OUT sticky flags are set (including same-cycle pulses), SHALL go to UPDATEIDX.
REQ-015 UPDATEIDX: one cycle; if iter_idx_o+1 == latched nb_iter go to TERMINATE, else increment iter_idx_o and go to START.
REQ-016 TERMINATE: one cycle; SHALL pulse done_o, go to IDLE; iter_idx_o holds last index.
REQ-017 busy_o SHALL be 1 in every state except IDLE.
REQ-018 trigger_i outside IDLE SHALL be ignored.
REQ-019 clear_i SHALL take priority over all other inputs: next state IDLE, counts, sticky flags, iter_idx_o, err_o zeroed, engine_clear_o pulsed one cycle; no done_o.
REQ-020 All outputs SHALL be registered; pulses last exactly one cycle.
REQ-021 Minimum per-tile overhead SHALL be 3 cycles (START, WAIT exit, UPDATEIDX) beyond compute.

Reset
REQ-022 rst_i high SHALL asynchronously force state IDLE and all outputs, counts, flags, and latched values to 0; release takes effect at the next clk_i edge.
REQ-023 Reset mid-job SHALL abandon the job with no done_o.

Verification
REQ-024 N_OUT=2, nb_iter=3, limits {4,2}, all handshakes then done pulses -> three START pulses, iter_idx 0,1,2, single done_o, err_o=0.
REQ-025 nb_iter=0 with trigger -> done_o one cycle later, busy_o never 1.
REQ-026 sink_done_i pulses during COMPUTE before count reaches limit -> FSM still exits WAIT without a repeated pulse.
REQ-027 Extra out_hs_i after limit 2 reached -> err_o=1, cnt stays 2, job completes normally.
REQ-028 clear_i in COMPUTE with count=3 -> IDLE next cycle, cnt_o=0, engine_clear_o pulse, no done_o; rst_i mid-WAIT -> all outputs 0 immediately.
